// File: rtl/mult_shift_add_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_if
// Brief    : Start/operand/result bundle for the shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_shift_add_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input product);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output product);
endinterface
`default_nettype wire

// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add
// Brief    : Sequential unsigned shift-and-add multiplier, one ripple-carry
//            partial-product addition per clock. Optional macro
//            MULT_ZERO_BYPASS_EN completes zero-operand multiplies at once.
// Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add #(
    parameter int N = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mult_shift_add_if.slave  bus
);
    localparam int                 CNT_W  = $clog2(N + 1);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_mq;
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0]   r_product;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic             w_zero_op;
    logic [N-1:0]     w_addend;
    logic [N-1:0]     w_sum;
    logic [N:0]       w_carry;

    assign w_last    = (r_cnt == C_LAST);
    assign w_addend  = r_mq[0] ? r_mcand : '0;

`ifdef MULT_ZERO_BYPASS_EN
    assign w_zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    // n-bit ripple-carry adder, carry_in tied low
    assign w_carry[0] = 1'b0;
    for (genvar gi = 0; gi < N; gi++) begin : g_rca
        assign w_sum[gi]       = r_acc[gi] ^ w_addend[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (r_acc[gi] & w_addend[gi]) |
                                 (w_carry[gi] & (r_acc[gi] ^ w_addend[gi]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero_op ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The adder carry shifts into the top of the accumulator, so no bit is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand <= bus.a;
                        r_mq    <= bus.b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        if (w_zero_op) begin
                            r_product <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= {w_carry[N], w_sum[N-1:1]};
                    r_mq  <= {w_sum[0], r_mq[N-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= {w_carry[N], w_sum, r_mq[N-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;
endmodule
`default_nettype wire

// File: doc/mult_shift_add.md
# mult_shift_add

Sequential unsigned shift-and-add multiplier that drives the n-bit ripple-carry adder stage with one partial-product addition per clock. It latches two n-bit operands on a start strobe and iterates n times, adding the multiplicand into the upper accumulator half when the current multiplier bit is 1. The adder's carry_out is captured each step. It returns a 2n-bit product with a one-cycle done pulse. It sits upstream of the adder as its operand sequencer and downstream as the consumer of its sum/carry.

## Interface
- n, 8, operand width; legal range 2..32; product width is 2n
- clk  input  1  rising-edge clock; all state updates on this edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a multiply; sampled only in IDLE
- a  input  n  multiplicand; latched on accepted start
- b  input  n  multiplier; latched on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; product valid and stable from this cycle
- product  output  2n  result register; holds until the next completion

## Operation
- Registers:
  - mcand[n-1:0]
  - acc[n-1:0] (upper half)
  - mq[n-1:0] (multiplier/lower half)
  - cnt[$clog2(n+1)-1:0]
  - state
- States:
  - IDLE: start=1 latches mcand=a, mq=b, acc=0, cnt=0, then goes to RUN. start=0 stays in IDLE.
  - RUN, each edge:
    - {c, s} = acc + (mq[0] ? mcand : 0), using the n-bit adder with carry_in=0.
    - {acc, mq} <= {c, s, mq} >> 1, i.e. acc <= {c, s[n-1:1]} and mq <= {s[0], mq[n-1:1]}.
    - cnt <= cnt+1.
    - When cnt==n-1 on this edge, product <= the shifted {acc, mq} value and the state goes to DONE.
  - DONE: done=1 for exactly one cycle; the next edge goes unconditionally to IDLE.
- Arithmetic is unsigned and the result is exact: product = a*b, with maximum (2^n-1)^2 < 2^(2n). The adder carry is never dropped; it becomes acc[n-1] after the shift.
- start is ignored in RUN and DONE; no queuing.
- Changes to a/b after acceptance have no effect.
- Reset, including mid-operation:
  - state=IDLE, busy=0, done=0, product=0, acc=0, mq=0, cnt=0, mcand=0.
  - An in-flight result is discarded.
  - rst has priority over start on the same edge.

## Timing
- Edge E0 accepts start.
- busy=1 in the cycles following E0 through En (n cycles).
- Iterations occur on edges E1..En; product is updated at En.
- done=1 during the cycle after En; product is valid from that cycle.
- Return to IDLE at E(n+1). The earliest next start is sampled at E(n+2), giving a throughput of one multiply per n+2 cycles.
- busy and done are never high together.
- product changes only at the completing edge (or at reset) and holds its value otherwise.

## Configuration
- Macro MULT_ZERO_BYPASS_EN:
  - Defined: if a==0 or b==0 at the accepted start, go IDLE -> DONE directly with product <= 0. done is then high in the cycle after E0 and busy stays 0 throughout.
  - Undefined: zero operands take the full n-iteration path, with the same timing as any other operand.

## Test plan
- n=8, a=13, b=11, start pulse at E0 -> busy high for 8 cycles; done high only in the cycle after E8; product=143.
- n=8, a=255, b=255 -> product=65025 (16'hFE01); checks that the carry_out captured at each step propagates into the upper half.
- n=8, a=0, b=200:
  - MULT_ZERO_BYPASS_EN defined -> done in the cycle after E0, product=0, busy never high.
  - MULT_ZERO_BYPASS_EN undefined -> done after E8, product=0.
- a=7, b=9 accepted; start re-asserted with a=3, b=3 during RUN and in the DONE cycle -> both ignored, product=63. A later start in IDLE with a=3, b=3 -> product=9.
- a=100, b=100 accepted; rst=1 for one edge at E4 -> after that edge busy=0, done=0, product=0, no done pulse follows. A new start with a=2, b=5 -> product=10 at the normal latency.
- Back-to-back: start held high continuously with a=6, b=7 -> results complete every n+2 cycles, each with product=42 and exactly one done pulse.
